// File: rtl/icache_direct_pkg.sv
// Shared configuration, FSM encoding and address-field helpers for the
// direct-mapped instruction cache.
package icache_direct_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_LINES  = 64;
  localparam int DEF_WORDS  = 4;

  localparam int OFF_W = $clog2(DEF_WORDS);
  localparam int IDX_W = $clog2(DEF_LINES);
  localparam int TAG_W = DEF_ADDR_W - IDX_W - OFF_W - 2;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REQ,
    ST_FILL,
    ST_RESP
  } state_e;

  function automatic logic [TAG_W-1:0] TAG(input logic [DEF_ADDR_W-1:0] a);
    return a[DEF_ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] INDEX(input logic [DEF_ADDR_W-1:0] a);
    return a[2+OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] OFFSET(input logic [DEF_ADDR_W-1:0] a);
    return a[2 +: OFF_W];
  endfunction

  function automatic logic [DEF_ADDR_W-1:0] LINE_BASE(input logic [DEF_ADDR_W-1:0] a);
    return {a[DEF_ADDR_W-1:2+OFF_W], {(OFF_W+2){1'b0}}};
  endfunction

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-port and refill-bus signals of the instruction cache; the cache is
// the slave, the core/memory environment is the master.
interface icache_direct_if
  import icache_direct_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic [ADDR_W-1:0] imem_addr;
  logic              imem_oe;
  logic [31:0]       imem_rdata;
  logic              imem_ready;
  logic              flush;
  logic              bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;

  modport slave (
    input  imem_addr, imem_oe, flush, bus_gnt, bus_rvalid, bus_rdata,
    output imem_rdata, imem_ready, bus_req, bus_addr
  );

  modport master (
    output imem_addr, imem_oe, flush, bus_gnt, bus_rvalid, bus_rdata,
    input  imem_rdata, imem_ready, bus_req, bus_addr
  );

endinterface

// File: rtl/icache_direct_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle
// read latency, read data holds while re_i is low); no flow control.
module sdp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped I-cache: hits return one cycle after acceptance; a miss drops
// imem_ready, refills the whole line over the word bus, then delivers the word.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int          ADDR_W   = DEF_ADDR_W,
  parameter int          LINES    = DEF_LINES,
  parameter int          WORDS    = DEF_WORDS,
  parameter logic [31:0] NOP_INSN = NOP
) (
  input logic              clk,
  input logic              rst_n,
  icache_direct_if.slave   port_io
);

  // Field extraction lives in the package, so the geometry is fixed there.
  if (ADDR_W != DEF_ADDR_W || LINES != DEF_LINES || WORDS != DEF_WORDS) begin : g_cfg_check
    $error("icache_direct geometry must match icache_direct_pkg defaults");
  end

  localparam int DA_W = IDX_W + OFF_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         cap_q, cap_d;
  logic [OFF_W-1:0]    beat_q, beat_d;
  logic                flush_seen_q, flush_seen_d;

  logic [31:0]         data_rd;
  logic [TAG_W-1:0]    tag_rd;
  logic                hit;
  logic                lookup_miss;
  logic                accept;
  logic                fill_we;
  logic                last_beat;
  logic                cap_beat;

  always_comb begin
    hit         = (state_q == ST_LOOKUP) && valid_q[INDEX(addr_q)] &&
                  (tag_rd == TAG(addr_q));
    lookup_miss = (state_q == ST_LOOKUP) && !hit;
    accept      = port_io.imem_oe &&
                  ((state_q == ST_IDLE) || (state_q == ST_RESP) || hit);
    fill_we     = (state_q == ST_FILL) && port_io.bus_rvalid;
    last_beat   = fill_we && (beat_q == OFF_W'(WORDS - 1));
    cap_beat    = fill_we && (beat_q == OFFSET(addr_q));
  end

  sdp_ram #(
    .WIDTH (32),
    .DEPTH (LINES * WORDS)
  ) u_data_ram (
    .clk_i   (clk),
    .we_i    (fill_we),
    .waddr_i ({INDEX(addr_q), beat_q}),
    .wdata_i (port_io.bus_rdata),
    .re_i    (accept),
    .raddr_i (DA_W'({INDEX(port_io.imem_addr), OFFSET(port_io.imem_addr)})),
    .rdata_o (data_rd)
  );

  sdp_ram #(
    .WIDTH (TAG_W),
    .DEPTH (LINES)
  ) u_tag_ram (
    .clk_i   (clk),
    .we_i    (last_beat),
    .waddr_i (INDEX(addr_q)),
    .wdata_i (TAG(addr_q)),
    .re_i    (accept),
    .raddr_i (INDEX(port_io.imem_addr)),
    .rdata_o (tag_rd)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    rdata_d      = rdata_q;
    cap_d        = cap_q;
    beat_d       = beat_q;
    flush_seen_d = flush_seen_q | port_io.flush;

    if (accept) begin
      addr_d = port_io.imem_addr;
    end

    case (state_q)
      ST_IDLE: begin
        if (port_io.imem_oe) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        flush_seen_d = port_io.flush;
        if (hit) begin
          rdata_d = data_rd;
          state_d = port_io.imem_oe ? ST_LOOKUP : ST_IDLE;
        end else begin
          valid_d[INDEX(addr_q)] = 1'b0;
          beat_d  = '0;
          // A grant in the miss cycle itself still counts as accepted.
          state_d = port_io.bus_gnt ? ST_FILL : ST_REQ;
        end
      end
      ST_REQ: begin
        beat_d = '0;
        if (port_io.bus_gnt) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (fill_we) begin
          beat_d = beat_q + 1'b1;
        end
        if (cap_beat) begin
          cap_d = port_io.bus_rdata;
        end
        if (last_beat) begin
          rdata_d = cap_beat ? port_io.bus_rdata : cap_q;
          if (!(flush_seen_q || port_io.flush)) valid_d[INDEX(addr_q)] = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = port_io.imem_oe ? ST_LOOKUP : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (port_io.flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      valid_q      <= '0;
      rdata_q      <= NOP_INSN;
      cap_q        <= '0;
      beat_q       <= '0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      rdata_q      <= rdata_d;
      cap_q        <= cap_d;
      beat_q       <= beat_d;
      flush_seen_q <= flush_seen_d;
    end
  end

  // rdata only follows the RAM in a hit cycle; otherwise it holds the last word.
  always_comb begin
    port_io.imem_ready = !(lookup_miss || (state_q == ST_REQ) || (state_q == ST_FILL));
    port_io.imem_rdata = hit ? data_rd : rdata_q;
    port_io.bus_req    = lookup_miss || (state_q == ST_REQ);
    port_io.bus_addr   = LINE_BASE(addr_q);
  end

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: table-driven hit vectors plus hand-written
// miss/refill, flush and reset-abort sequences.
module tb_icache_direct;

  logic clk;
  logic rst_n;

  icache_direct_if #(.ADDR_W(16)) cif ();

  icache_direct dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .port_io (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_del;

  typedef struct {
    logic [15:0] addr;
    logic        oe;
    logic        exp_rdy;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [31:0] mkword(input logic [7:0] g, input logic [15:0] a);
    return {g, 8'h00, a & 16'hFFFC};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hit(input logic [15:0] a, input logic [31:0] exp);
    cif.imem_addr = a;
    cif.imem_oe   = 1'b1;
    tick();
    cif.imem_oe = 1'b0;
    #2;
    chk("hit_ready", 32'(cif.imem_ready), 32'd1);
    chk("hit_rdata", cif.imem_rdata, exp);
    chk("hit_noreq", 32'(cif.bus_req), 32'd0);
    last_del = exp;
    tick();
  endtask

  // Full miss sequence; abort_beats >= 0 drops reset in that beat's cycle.
  task automatic miss(input logic [15:0] a, input logic [7:0] g, input int gd,
                      input int gap, input int fl_beat, input bit fl_acc,
                      input int abort_beats);
    logic [15:0] base;
    logic [31:0] exp;
    base = a & 16'hFFF0;
    exp  = mkword(g, a);
    cif.imem_addr = a;
    cif.imem_oe   = 1'b1;
    cif.flush     = fl_acc;
    #2;
    chk("acc_ready", 32'(cif.imem_ready), 32'd1);
    tick();
    cif.flush     = 1'b0;
    cif.imem_addr = 16'($urandom);
    #2;
    chk("lookup_ready", 32'(cif.imem_ready), 32'd0);
    chk("lookup_req", 32'(cif.bus_req), 32'd1);
    chk("lookup_addr", 32'(cif.bus_addr), 32'(base));
    chk("lookup_rdata", cif.imem_rdata, last_del);
    for (int k = 0; k <= gd; k++) begin
      tick();
      cif.bus_gnt   = (k == gd);
      cif.imem_addr = 16'($urandom);
      #2;
      chk("req_req", 32'(cif.bus_req), 32'd1);
      chk("req_addr", 32'(cif.bus_addr), 32'(base));
      chk("req_ready", 32'(cif.imem_ready), 32'd0);
    end
    tick();
    cif.bus_gnt = 1'b0;
    for (int w = 0; w < 4; w++) begin
      for (int gp = 0; gp < gap; gp++) begin
        cif.bus_rvalid = 1'b0;
        cif.bus_rdata  = $urandom;
        #2;
        chk("gap_ready", 32'(cif.imem_ready), 32'd0);
        chk("gap_req", 32'(cif.bus_req), 32'd0);
        tick();
      end
      cif.bus_rvalid = 1'b1;
      cif.bus_rdata  = mkword(g, base | 16'(w << 2));
      cif.flush      = (w == fl_beat);
      if (w == abort_beats) begin
        rst_n = 1'b0;
        #1;
        chk("abort_req", 32'(cif.bus_req), 32'd0);
        chk("abort_ready", 32'(cif.imem_ready), 32'd1);
        chk("abort_rdata", cif.imem_rdata, 32'h0000_0013);
        chk("abort_addr", 32'(cif.bus_addr), 32'd0);
        cif.bus_rvalid = 1'b0;
        cif.flush      = 1'b0;
        cif.imem_oe    = 1'b0;
        #2;
        rst_n    = 1'b1;
        last_del = 32'h0000_0013;
        tick();
        return;
      end
      #2;
      chk("fill_ready", 32'(cif.imem_ready), 32'd0);
      chk("fill_rdata", cif.imem_rdata, last_del);
      tick();
      cif.flush = 1'b0;
    end
    cif.bus_rvalid = 1'b0;
    cif.imem_oe    = 1'b0;
    #2;
    chk("resp_ready", 32'(cif.imem_ready), 32'd1);
    chk("resp_rdata", cif.imem_rdata, exp);
    chk("resp_req", 32'(cif.bus_req), 32'd0);
    last_del = exp;
    tick();
  endtask

  initial begin
    rst_n          = 1'b0;
    cif.imem_addr  = '0;
    cif.imem_oe    = 1'b0;
    cif.flush      = 1'b0;
    cif.bus_gnt    = 1'b0;
    cif.bus_rvalid = 1'b0;
    cif.bus_rdata  = '0;
    last_del       = 32'h0000_0013;

    #12;
    chk("rst_ready", 32'(cif.imem_ready), 32'd1);
    chk("rst_rdata", cif.imem_rdata, 32'h0000_0013);
    chk("rst_req", 32'(cif.bus_req), 32'd0);
    chk("rst_addr", 32'(cif.bus_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    // Cold miss on word 2 of line 0.
    miss(16'h0008, 8'hA0, 1, 0, -1, 1'b0, -1);

    // Back-to-back hits; each row is one cycle, outputs reflect the previous row.
    tbl[0] = '{16'h0000, 1'b1, 1'b1, 32'hA000_0008};
    tbl[1] = '{16'h0004, 1'b1, 1'b1, 32'hA000_0000};
    tbl[2] = '{16'h000C, 1'b1, 1'b1, 32'hA000_0004};
    tbl[3] = '{16'h0008, 1'b1, 1'b1, 32'hA000_000C};
    tbl[4] = '{16'h0000, 1'b0, 1'b1, 32'hA000_0008};
    tbl[5] = '{16'h0000, 1'b0, 1'b1, 32'hA000_0008};
    for (int i = 0; i < 6; i++) begin
      cif.imem_addr = tbl[i].addr;
      cif.imem_oe   = tbl[i].oe;
      #2;
      chk($sformatf("vec%0d_ready", i), 32'(cif.imem_ready), 32'(tbl[i].exp_rdy));
      chk($sformatf("vec%0d_rdata", i), cif.imem_rdata, tbl[i].exp_dat);
      chk($sformatf("vec%0d_noreq", i), 32'(cif.bus_req), 32'd0);
      tick();
    end

    // Hold: rdata must stay put with oe low, whatever the bus does.
    hit(16'h0004, 32'hA000_0004);
    for (int i = 0; i < 5; i++) begin
      cif.bus_gnt    = 1'($urandom_range(0, 1));
      cif.bus_rvalid = 1'($urandom_range(0, 1));
      cif.bus_rdata  = $urandom;
      #2;
      chk("hold_rdata", cif.imem_rdata, 32'hA000_0004);
      chk("hold_ready", 32'(cif.imem_ready), 32'd1);
      tick();
    end
    cif.bus_gnt    = 1'b0;
    cif.bus_rvalid = 1'b0;

    // Conflict miss on index 0, then the evicted line misses again.
    miss(16'h0400, 8'hB0, 2, 1, -1, 1'b0, -1);
    miss(16'h0000, 8'hC0, 0, 2, -1, 1'b0, -1);
    hit(16'h0008, 32'hC000_0008);

    // Flush in idle, then flush coinciding with acceptance.
    cif.flush = 1'b1;
    #2;
    tick();
    cif.flush = 1'b0;
    miss(16'h0004, 8'hD0, 0, 0, -1, 1'b0, -1);
    hit(16'h000C, 32'hD000_000C);
    miss(16'h0008, 8'hE0, 1, 0, -1, 1'b1, -1);
    hit(16'h0000, 32'hE000_0000);

    // Flush during fill: word delivered but the line stays invalid.
    miss(16'h0010, 8'hF0, 0, 1, 2, 1'b0, -1);
    miss(16'h0014, 8'h71, 0, 0, -1, 1'b0, -1);
    hit(16'h0018, 32'h7100_0018);

    // Reset after two of four beats, then the line must miss.
    miss(16'h0020, 8'h90, 0, 0, -1, 1'b0, 2);
    miss(16'h0024, 8'h92, 1, 0, -1, 1'b0, -1);
    hit(16'h002C, 32'h9200_002C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped instruction cache between the core's instruction-fetch port (imem_*) and a slower word-wide backing memory bus (bus_*).
- Accepts one fetch per cycle. A hit returns data one cycle later, which matches the core's 1-cycle imem latency.
- A miss holds imem_ready low, refills the whole line from the bus, then delivers the requested word.
- Provides a flush input for FENCE.I / boot-time invalidation.

Parameters:
- ADDR_W, 16, byte-address width of imem_addr and bus_addr.
- LINES, 64, number of lines; power of 2.
- WORDS, 4, 32-bit words per line; power of 2, at least 2.
- NOP_INSN, 32'h00000013, value driven on imem_rdata after reset.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- imem_oe  in  1  fetch request; accepted when the cache is idle.
- imem_rdata  out  32  fetched instruction.
- imem_ready  out  1  low only while a miss is outstanding.
- flush  in  1  single-cycle pulse; invalidates all lines.
- bus_req  out  1  refill request; held high until granted.
- bus_addr  out  ADDR_W  line-aligned byte address of the refill.
- bus_gnt  in  1  request accepted when bus_req and bus_gnt are both high.
- bus_rvalid  in  1  one refill beat is present this cycle.
- bus_rdata  in  32  beat data; beats arrive in order, word 0 first.

Behaviour:
- Address split: offset = addr[2+:log2 WORDS]; index = next log2 LINES bits; tag = remaining upper bits. Defaults give tag = addr[15:10] and index = addr[9:4].
- Storage:
  - Data array and tag array are synchronous-read RAMs.
  - Valid bits are a flop vector so they can be cleared in one cycle.
- Reset (async, rst_n low):
  - State IDLE; all valid bits 0.
  - imem_ready=1; imem_rdata=NOP_INSN.
  - bus_req=0; bus_addr=0.
  - Asserting reset mid-refill aborts the refill immediately; the bus tolerates a dropped request.
- FSM states: IDLE, LOOKUP, REQ, FILL, RESP.
  - IDLE: if imem_oe, latch the address, read both arrays at the index, and go to LOOKUP. Otherwise stay in IDLE.
  - LOOKUP (cycle T+1), hit = valid & tag match:
    - Hit: imem_ready=1, imem_rdata=word at offset, latch that word. If imem_oe, accept the next request (pipelined back-to-back hits); otherwise go to IDLE.
    - Miss: imem_ready=0, bus_req=1, bus_addr=line base, clear valid[index], go to REQ.
  - REQ: hold bus_req/bus_addr stable until bus_gnt is sampled high, then go to FILL. bus_req is low from the cycle after the grant.
  - FILL:
    - On each bus_rvalid, write bus_rdata to data[index][beat] and increment the beat counter.
    - When beat == offset, also capture the word.
    - On the last beat (beat == WORDS-1): write the tag, set valid[index] (unless a flush was seen during the refill), go to RESP.
    - Gaps between beats are allowed.
  - RESP: imem_ready=1, imem_rdata=captured word; accept a new request as in IDLE.
- imem_ready: 0 exactly in the cycles spent in REQ or FILL, and in the LOOKUP cycle of a miss. 1 otherwise.
- imem_rdata holding rule:
  - While imem_oe is low, imem_rdata keeps the last delivered word.
  - Across miss cycles it also keeps the last delivered word.
  - The core feeds imem_rdata combinationally into decode, so it must not glitch to RAM output when no request is pending.
- imem_oe is ignored in REQ and FILL; the address latched at acceptance is the one served.
- flush:
  - Clears all valid bits at the next edge.
  - If flush coincides with acceptance of a request, that request misses.
  - If flush arrives during REQ or FILL, the refill completes and the word is delivered, but the line stays invalid.
- Beat counter: log2 WORDS bits; resets to 0 when entering FILL.

Decomposition:
- Shared package holds:
  - NOP constant.
  - FSM state encoding.
  - Field-width localparams: OFF_W, IDX_W, TAG_W.
  - Field-extract functions: TAG, INDEX, OFFSET.
- One sub-module: sdp_ram (simple dual-port, 1 write / 1 sync read, parameterised width and depth). Instantiate it twice: data array and tag array.

Test Plan:
1. Cold miss: imem_oe with addr 0x0008 after reset.
   - bus_req=1 and bus_addr=0x0000 in cycle 1.
   - Grant and beats A0..A3 follow; the cycle after beat A3, imem_ready=1 and imem_rdata=A2.
2. Back-to-back hits: oe on consecutive cycles at 0x0000, 0x0004, 0x000C.
   - imem_rdata A0, A1, A3 on consecutive cycles; imem_ready stays 1; no bus_req.
3. Conflict miss: fetch 0x0400 (same index 0, tag 1).
   - Refill with beats B0..B3; returns B0.
   - A later fetch of 0x0000 misses again (bus_req=1).
4. Hold/stall: after a hit returning A1, hold imem_oe=0 for 5 cycles while driving random bus inputs.
   - imem_rdata stays A1; imem_ready stays 1.
5. Flush: pulse flush, then fetch 0x0004 → miss with refill.
   - Variant: flush during FILL → word delivered, then a refetch of the same line misses.
6. Reset mid-fill: drop rst_n after 2 of 4 beats.
   - bus_req=0, imem_ready=1, imem_rdata=0x00000013 immediately.
   - A refetch of that line misses.
